// File: rtl/bram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bram_rr_arbiter
//   Round-robin arbiter that shares one simple dual-port BRAM between NREQ
//   requesters. Accepts at most one read or write command per cycle, drives
//   BRAM port A (write) and port B (read address), and returns read data two
//   cycles after acceptance, tagged with the issuing requester's index.
//
// Optional feature (macro BRAM_ARB_LOCK_EN):
//   Adds req_lock. An accepted command with its lock bit set pins arbitration
//   to that requester until it issues an unlocked command or drops valid.
//
// Ports:
//   clk         single clock for arbiter and BRAM
//   rst         asynchronous active-high reset
//   en          global grant enable (low = no new grants)
//   req_valid   per-requester command valid
//   req_ready   per-requester grant, one-hot or zero (combinational)
//   req_we      per-requester command type, 1 = write
//   req_addr    packed addresses, requester i at [i*ADDR +: ADDR]
//   req_wdata   packed write data, requester i at [i*DATA +: DATA]
//   req_lock    (BRAM_ARB_LOCK_EN only) per-requester lock request
//   rsp_valid   read data valid
//   rsp_id      owner of rsp_data
//   rsp_data    read data, bram_doutb passed through
//   bram_wea    BRAM port A write enable
//   bram_addra  BRAM port A address
//   bram_dina   BRAM port A write data
//   bram_addrb  BRAM port B address
//   bram_doutb  BRAM port B registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module bram_rr_arbiter #(
  parameter int unsigned DATA = 128,
  parameter int unsigned ADDR = 9,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR-1:0]   req_addr,
  input  logic [NREQ*DATA-1:0]   req_wdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]        req_lock,
`endif
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA-1:0]        rsp_data,
  output logic                   bram_wea,
  output logic [ADDR-1:0]        bram_addra,
  output logic [DATA-1:0]        bram_dina,
  output logic [ADDR-1:0]        bram_addrb,
  input  logic [DATA-1:0]        bram_doutb
);

  // Index of the most recently granted requester; search starts just after it.
  logic [IDW-1:0]  rr_ptr;

  // Arbitration results for the current cycle.
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;
  logic            accept;

  // Command fields of the winning requester.
  logic [ADDR-1:0] addr_a [NREQ];
  logic [DATA-1:0] wdata_a [NREQ];
  logic            sel_we;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_wdata;

  // Read token in the address stage (cycle after acceptance).
  logic            rd1_valid;
  logic [IDW-1:0]  rd1_id;

  // Unpack per-requester address and data buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR +: ADDR];
    assign wdata_a[g] = req_wdata[g*DATA +: DATA];
  end

`ifdef BRAM_ARB_LOCK_EN
  logic           lock_q;
  logic [IDW-1:0] lock_owner;

  // While locked, only the owner may compete.
  always_comb begin
    elig = req_valid;
    if (lock_q) begin
      elig = req_valid & (NREQ'(1) << lock_owner);
    end
  end

  // Lock follows the lock bit of each accepted command; owner dropping valid
  // releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_owner <= '0;
    end else if (accept) begin
      lock_q     <= req_lock[win];
      lock_owner <= win;
    end else if (lock_q && !req_valid[lock_owner]) begin
      lock_q     <= 1'b0;
    end
  end
`else
  always_comb begin
    elig = req_valid;
  end
`endif

  // Rotating priority search: rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant is suppressed while reset is asserted so it drops immediately.
  always_comb begin
    req_ready = '0;
    if (en && found && !rst) begin
      req_ready[win] = 1'b1;
    end
  end

  assign accept = en & found & ~rst;

  // Winner's command fields.
  always_comb begin
    sel_we    = req_we[win];
    sel_addr  = addr_a[win];
    sel_wdata = wdata_a[win];
  end

  // Round-robin pointer: moves to the winner on every acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (accept) begin
      rr_ptr <= win;
    end
  end

  // Port A: write issued the cycle after acceptance; address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
    end else begin
      bram_wea <= accept & sel_we;
      if (accept && sel_we) begin
        bram_addra <= sel_addr;
        bram_dina  <= sel_wdata;
      end
    end
  end

  // Port B address stage: address holds its last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_addrb <= '0;
      rd1_valid  <= 1'b0;
      rd1_id     <= '0;
    end else begin
      rd1_valid <= accept & ~sel_we;
      if (accept && !sel_we) begin
        bram_addrb <= sel_addr;
        rd1_id     <= win;
      end
    end
  end

  // Response stage aligned with the BRAM's registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= rd1_valid;
      if (rd1_valid) begin
        rsp_id <= rd1_id;
      end
    end
  end

  assign rsp_data = bram_doutb;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
module tb_bram_rr_arbiter;

  localparam int DATA  = 128;
  localparam int ADDR  = 9;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 1 << ADDR;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we = '0;
  logic [NREQ*ADDR-1:0] req_addr = '0;
  logic [NREQ*DATA-1:0] req_wdata = '0;
`ifdef BRAM_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock = '0;
`endif
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [DATA-1:0]      rsp_data;
  logic                 bram_wea;
  logic [ADDR-1:0]      bram_addra;
  logic [DATA-1:0]      bram_dina;
  logic [ADDR-1:0]      bram_addrb;
  logic [DATA-1:0]      bram_doutb;

  int n_checks = 0;
  int n_fail   = 0;

  bram_rr_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  always #5 clk = ~clk;

  // Simple dual-port BRAM with read-first, registered port B.
  logic [DATA-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bram_wea) bram_mem[bram_addra] <= bram_dina;
    bram_doutb <= bram_mem[bram_addrb];
  end

  // Reference model: accepted commands in order, memory updated at acceptance.
  typedef struct {
    bit              v;
    bit              we;
    int              id;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
  } cmd_t;

  logic [DATA-1:0] ref_mem [DEPTH];
  int              m_ptr;
  cmd_t            c1, c2, nc;
  logic [ADDR-1:0] exp_addra, exp_addrb;
  logic [DATA-1:0] exp_dina;
  int              mw;

  function automatic bit vbit(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = (v >> i) & NREQ'(1);
    return |t;
  endfunction

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (vbit(v, (ptr + k) % NREQ)) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [ADDR-1:0] addr_of(input int i);
    return ADDR'(req_addr >> (i * ADDR));
  endfunction

  function automatic logic [DATA-1:0] data_of(input int i);
    return DATA'(req_wdata >> (i * DATA));
  endfunction

  task automatic check(input string name, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr     = NREQ - 1;
      c1.v      = 1'b0;
      c2.v      = 1'b0;
      exp_addra = '0;
      exp_addrb = '0;
      exp_dina  = '0;
    end else begin
      c2   = c1;
      nc.v = 1'b0;
      mw   = pick(m_ptr, req_valid);
      if (en && mw >= 0) begin
        nc.v    = 1'b1;
        nc.we   = vbit(req_we, mw);
        nc.id   = mw;
        nc.addr = addr_of(mw);
        if (nc.we) begin
          nc.data = data_of(mw);
          ref_mem[nc.addr] = nc.data;
        end else begin
          nc.data = ref_mem[nc.addr];
        end
        m_ptr = mw;
      end
      c1 = nc;
      if (c1.v && c1.we) begin
        exp_addra = c1.addr;
        exp_dina  = c1.data;
      end
      if (c1.v && !c1.we) exp_addrb = c1.addr;
    end
  end

  // Every-cycle comparison against the model.
  int              cw;
  logic [NREQ-1:0] cready;
  always @(negedge clk) begin
    if (!rst) begin
      cw     = pick(m_ptr, req_valid);
      cready = (en && cw >= 0) ? (NREQ'(1) << cw) : '0;
      check("req_ready", DATA'(req_ready), DATA'(cready));
      check("bram_wea", DATA'(bram_wea), DATA'(c1.v && c1.we));
      check("bram_addra", DATA'(bram_addra), DATA'(exp_addra));
      check("bram_dina", bram_dina, exp_dina);
      check("bram_addrb", DATA'(bram_addrb), DATA'(exp_addrb));
      check("rsp_valid", DATA'(rsp_valid), DATA'(c2.v && !c2.we));
      if (c2.v && !c2.we) begin
        check("rsp_id", DATA'(rsp_id), DATA'(c2.id));
        check("rsp_data", rsp_data, c2.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input bit v, input bit we,
                         input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    logic [NREQ*ADDR-1:0] am;
    logic [NREQ*DATA-1:0] dm;
    am        = (NREQ*ADDR)'({ADDR{1'b1}}) << (i * ADDR);
    dm        = (NREQ*DATA)'({DATA{1'b1}}) << (i * DATA);
    req_addr  = (req_addr & ~am) | ((NREQ*ADDR)'(a) << (i * ADDR));
    req_wdata = (req_wdata & ~dm) | ((NREQ*DATA)'(d) << (i * DATA));
    req_valid = (req_valid & ~(NREQ'(1) << i)) | (NREQ'(v) << i);
    req_we    = (req_we & ~(NREQ'(1) << i)) | (NREQ'(we) << i);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    req_we    = '0;
    en        = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [DATA-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int              cnt [NREQ];
  logic [NREQ-1:0] g;

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      bram_mem[k] = DATA'(k + 100);
      ref_mem[k]  = DATA'(k + 100);
    end
    bram_doutb = '0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;

    // Reset state with every requester asking for service.
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '1;
    #12;
    check("reset_req_ready", DATA'(req_ready), '0);
    check("reset_rsp_valid", DATA'(rsp_valid), '0);
    check("reset_rsp_id", DATA'(rsp_id), '0);
    check("reset_bram_wea", DATA'(bram_wea), '0);
    check("reset_bram_addra", DATA'(bram_addra), '0);
    check("reset_bram_dina", bram_dina, '0);
    check("reset_bram_addrb", DATA'(bram_addrb), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All four continuously valid: strict rotation 0,1,2,3,...
    for (int cyc = 0; cyc < 100; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'b1, 1'($urandom_range(0, 1)), ADDR'($urandom_range(32, 63)), rand_data());
      @(negedge clk);
      g = req_ready;
      for (int i = 0; i < NREQ; i++) if (g == (NREQ'(1) << i)) cnt[i]++;
      if (cyc < 4) check("rr_first_grants", DATA'(g), DATA'(NREQ'(1) << cyc));
      tick();
    end
    for (int i = 0; i < NREQ; i++) check("rr_grant_count", DATA'(cnt[i]), DATA'(25));
    idle(3);

    // Read-after-write: requester 1 writes, requester 2 reads next cycle.
    set_cmd(1, 1'b1, 1'b1, ADDR'(16), DATA'(8'hA5));
    @(negedge clk);
    check("raw_write_grant", DATA'(req_ready), DATA'(4'b0010));
    tick();
    req_valid = '0;
    set_cmd(2, 1'b1, 1'b0, ADDR'(16), '0);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    check("raw_rsp_valid", DATA'(rsp_valid), DATA'(1));
    check("raw_rsp_id", DATA'(rsp_id), DATA'(2));
    check("raw_rsp_data", rsp_data, DATA'(8'hA5));
    tick();
    idle(2);

    // Back-to-back reads of preloaded addresses 0..7 by requester 0.
    for (int k = 0; k <= 10; k++) begin
      req_valid = '0;
      if (k < 8) set_cmd(0, 1'b1, 1'b0, ADDR'(k), '0);
      @(negedge clk);
      if (k < 8) check("b2b_grant", DATA'(req_ready), DATA'(4'b0001));
      if (k >= 2 && k < 10) begin
        check("b2b_rsp_valid", DATA'(rsp_valid), DATA'(1));
        check("b2b_rsp_data", rsp_data, DATA'(100 + k - 2));
      end else begin
        check("b2b_rsp_idle", DATA'(rsp_valid), DATA'(0));
      end
      tick();
    end
    idle(2);

    // en low for 5 cycles with one read in flight.
    set_cmd(0, 1'b1, 1'b0, ADDR'(3), '0);
    @(negedge clk);
    check("en_first_grant", DATA'(req_ready), DATA'(4'b0001));
    tick();
    for (int j = 1; j <= 5; j++) begin
      en = 1'b0;
      for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 1'b0, ADDR'(i), '0);
      @(negedge clk);
      check("en_low_ready", DATA'(req_ready), '0);
      if (j == 2) begin
        check("en_low_rsp_valid", DATA'(rsp_valid), DATA'(1));
        check("en_low_rsp_data", rsp_data, DATA'(103));
        check("en_low_rsp_id", DATA'(rsp_id), DATA'(0));
      end
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    check("en_resume_grant", DATA'(req_ready), DATA'(4'b0010));
    tick();
    idle(3);

    // Randomised traffic checked by the model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ADDR'($urandom_range(0, 15)), rand_data());
      en = ($urandom_range(0, 99) < 85);
      tick();
    end
    idle(3);

    // Asynchronous reset mid-cycle with a read in flight.
    set_cmd(0, 1'b1, 1'b0, ADDR'(5), '0);
    @(negedge clk);
    check("rst_pre_grant0", DATA'(req_ready), DATA'(4'b0001));
    tick();
    req_valid = '1;
    req_we    = '0;
    #1;
    check("rst_pre_grant1", DATA'(req_ready), DATA'(4'b0010));
    check("rst_pre_addrb", DATA'(bram_addrb), DATA'(5));
    #1 rst = 1'b1;
    #1;
    check("rst_async_ready", DATA'(req_ready), '0);
    check("rst_async_rsp_valid", DATA'(rsp_valid), '0);
    check("rst_async_wea", DATA'(bram_wea), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rst_dropped_rsp", DATA'(rsp_valid), '0);
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    check("rst_first_winner", DATA'(req_ready), DATA'(4'b0001));
    tick();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Single-clock round-robin arbiter that shares one simple dual-port block RAM between NREQ requesters.
- Each requester issues read or write commands through a valid/ready handshake.
- The block sequences the BRAM write port (wea/addra/dina) and read port (addrb), and routes registered read data back to the issuing requester, tagged with its ID.
- It sits between the stabilisation pipeline clients and a `bram` instance; both BRAM clocks are tied to `clk`.

Parameters:
- DATA, 128, BRAM word width in bits.
- ADDR, 9, BRAM address width in bits (depth 2**ADDR).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock for the arbiter and the BRAM.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global grant enable; low = no new grants.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester grant, one-hot or zero.
- req_we  in  NREQ  per-requester command type: 1 = write, 0 = read.
- req_addr  in  NREQ*ADDR  packed addresses; requester i uses bits [i*ADDR +: ADDR].
- req_wdata  in  NREQ*DATA  packed write data; requester i uses bits [i*DATA +: DATA].
- rsp_valid  out  1  read data valid.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  DATA  read data (bram_doutb passed through).
- bram_wea  out  1  to BRAM port A write enable.
- bram_addra  out  ADDR  to BRAM port A address.
- bram_dina  out  DATA  to BRAM port A data.
- bram_addrb  out  ADDR  to BRAM port B address.
- bram_doutb  in  DATA  from BRAM port B (registered output, one-cycle latency).

Behaviour:
- Reset (asynchronous, active-high):
  - req_ready, rsp_valid, bram_wea = 0.
  - rsp_id, bram_addra, bram_dina, bram_addrb = 0.
  - rr_ptr = NREQ-1, so requester 0 has highest priority first.
  - In-flight read tokens are cleared; a response pending at reset is dropped, never delivered.
- Arbitration (combinational, from registered state):
  - Winner = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[winner]=1 only when en=1; all other bits are 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake:
  - A command is accepted in cycle C when req_valid[i] & req_ready[i] = 1 at the rising edge ending C.
  - At most one command is accepted per cycle.
  - On acceptance, rr_ptr <= i. With no acceptance, rr_ptr holds.
- Write accepted in cycle C:
  - In cycle C+1: bram_wea=1, bram_addra=addr, bram_dina=wdata.
  - Memory is updated at the edge ending C+1.
  - bram_wea is 0 in every cycle with no write token.
- Read accepted in cycle C:
  - In cycle C+1: bram_addrb=addr.
  - In cycle C+2: rsp_valid=1, rsp_id=i, rsp_data=bram_doutb.
  - Fixed latency of 2 cycles; there is no backpressure on responses.
  - bram_addrb holds its last value when idle.
- Read-after-write: a read accepted in cycle C+1 (or later) after a write accepted in C to the same address returns the new data. No stall is needed because only one command is accepted per cycle.
- Throughput: one command per cycle sustained. Responses return in acceptance order.
- en low: no new acceptances. Commands already in flight still complete (write commits, read responds). rr_ptr holds.
- Requester withdrawing valid before ready is legal; the arbitration is recomputed each cycle.
- Single requester valid: it is granted every cycle, back-to-back.

Optional Feature:
- Macro: BRAM_ARB_LOCK_EN.
- Defined:
  - Adds input port req_lock, NREQ bits wide.
  - If an accepted command has req_lock[i]=1, a lock register is set to owner i.
  - While locked, only owner i can be granted; other requesters see req_ready=0 even if the owner is idle.
  - The lock clears on an accepted owner command with req_lock[i]=0, or in any cycle where req_valid[owner]=0.
  - rr_ptr still updates to i on each owner grant.
  - Reset clears the lock.
- Undefined:
  - The req_lock port is absent.
  - Arbitration is pure round-robin as above.

Test Plan:
- Reset then all four requesters valid continuously, en=1:
  - Grants go 0,1,2,3,0,... one per cycle.
  - Each requester gets exactly 25 grants in 100 cycles.
- Requester 1 writes 0xA5 to address 0x010 in cycle C; requester 2 reads 0x010 in cycle C+1:
  - rsp_valid=1 at C+3 with rsp_id=2 and rsp_data=0xA5.
- Back-to-back reads from requester 0 to addresses 0..7 (preloaded mem[k]=k+100):
  - rsp_valid is high for 8 consecutive cycles starting 2 cycles after the first grant.
  - rsp_data = 100..107 in order.
- en dropped for 5 cycles with one read in flight:
  - That response still appears 2 cycles after acceptance.
  - req_ready=0 throughout the 5 cycles.
  - After en returns, the grant resumes from rr_ptr+1.
- rst asserted asynchronously mid-cycle while a read is in flight:
  - rsp_valid, req_ready and bram_wea go low immediately.
  - No response is delivered.
  - After release, requester 0 wins first.
- BRAM_ARB_LOCK_EN: requester 3 holds lock for 4 writes while requesters 0-2 are valid:
  - Only requester 3 is granted for 4 cycles.
  - Then requester 0 is granted.
